piso8_tx: RTL and testbench

Parallel-in/serial-out transmit stage that sits directly downstream of the 8-bit storage register. It captures the register's parallel output word on a load handshake and shifts it out one bit per clock on a single serial line, with an optional trailing even-parity bit. The `busy` and `done` flags let the surrounding control logic reload the register for the next word.

---
 rtl/piso8_tx.sv | 127 ++++++++++++
 tb/tb_piso8_tx.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/piso8_tx.sv
// Parallel-in/serial-out transmitter: captures D on load and shifts it out on sout.
// Define PISO_PARITY_EN to append a trailing even-parity bit to every frame.
module piso8_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             load,
  output logic             ready,
  output logic             busy,
  output logic             sout,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifndef PISO_PARITY_EN
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT
`ifdef PISO_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    sout_d   = sout_q;
    done_d   = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        sout_d = 1'b1;
        if (load) begin
          state_d  = S_SHIFT;
          shreg_d  = D;
          cnt_d    = '0;
          sout_d   = (LSB_FIRST != 0) ? D[0] : D[WIDTH-1];
`ifdef PISO_PARITY_EN
          parity_d = ^D;
`endif
        end
      end
      S_SHIFT: begin
        if (cnt_q == LAST) begin
`ifdef PISO_PARITY_EN
          state_d = S_PARITY;
          sout_d  = parity_q;
          done_d  = 1'b1;
`else
          state_d = S_IDLE;
          sout_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
          // sout already shows the head bit, so the next bit sits one place in
          if (LSB_FIRST != 0) begin
            shreg_d = shreg_q >> 1;
            sout_d  = shreg_q[1];
          end else begin
            shreg_d = shreg_q << 1;
            sout_d  = shreg_q[WIDTH-2];
          end
`ifndef PISO_PARITY_EN
          done_d = (cnt_q == PENULT);
`endif
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        state_d = S_IDLE;
        sout_d  = 1'b1;
      end
`endif
      default: begin
        state_d = S_IDLE;
        sout_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      sout_q   <= 1'b1;
      done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      sout_q   <= sout_d;
      done_q   <= done_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q != S_IDLE);
  assign sout  = sout_q;
  assign done  = done_q;

endmodule

// File: tb/tb_piso8_tx.sv
// Directed self-checking bench for piso8_tx; one LSB-first and one MSB-first instance
// share the same stimulus. Parity cases are compiled in with PISO_PARITY_EN.
module tb_piso8_tx;

  localparam int unsigned W = 8;
`ifdef PISO_PARITY_EN
  localparam int unsigned FRAME = W + 1;
`else
  localparam int unsigned FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         CLR;
  logic [W-1:0] D;
  logic         load;

  logic ready_l, busy_l, sout_l, done_l;
  logic ready_m, busy_m, sout_m, done_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso8_tx #(.WIDTH(W), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .CLR(CLR), .D(D), .load(load),
    .ready(ready_l), .busy(busy_l), .sout(sout_l), .done(done_l)
  );

  piso8_tx #(.WIDTH(W), .LSB_FIRST(0)) u_msb (
    .clk(clk), .CLR(CLR), .D(D), .load(load),
    .ready(ready_m), .busy(busy_m), .sout(sout_m), .done(done_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected serial bit i of a frame carrying w (parity bit at index W).
  function automatic logic exp_bit(input logic [W-1:0] w, input int unsigned i, input bit lsb);
    if (i >= W) return ^w;
    return lsb ? w[i] : w[W-1-i];
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " ready_l"}, {31'b0, ready_l}, 32'd1);
    check({tag, " busy_l"},  {31'b0, busy_l},  32'd0);
    check({tag, " sout_l"},  {31'b0, sout_l},  32'd1);
    check({tag, " done_l"},  {31'b0, done_l},  32'd0);
    check({tag, " ready_m"}, {31'b0, ready_m}, 32'd1);
    check({tag, " busy_m"},  {31'b0, busy_m},  32'd0);
    check({tag, " sout_m"},  {31'b0, sout_m},  32'd1);
    check({tag, " done_m"},  {31'b0, done_m},  32'd0);
  endtask

  // Sends one frame starting from an idle cycle. Cycle numbers are 1-based after
  // the load edge; 0 disables the corresponding disturbance.
  task automatic run_frame(input string name, input logic [W-1:0] word,
                           input int unsigned zero_d_at, input int unsigned pulse_at);
    D    = word;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int unsigned i = 0; i < FRAME; i++) begin
      check($sformatf("%s c%0d sout_l", name, i + 1), {31'b0, sout_l}, {31'b0, exp_bit(word, i, 1'b1)});
      check($sformatf("%s c%0d sout_m", name, i + 1), {31'b0, sout_m}, {31'b0, exp_bit(word, i, 1'b0)});
      check($sformatf("%s c%0d done", name, i + 1), {31'b0, done_l}, {31'b0, (i == FRAME - 1)});
      check($sformatf("%s c%0d done_m", name, i + 1), {31'b0, done_m}, {31'b0, (i == FRAME - 1)});
      check($sformatf("%s c%0d busy", name, i + 1), {31'b0, busy_l}, 32'd1);
      check($sformatf("%s c%0d ready", name, i + 1), {31'b0, ready_l}, 32'd0);
      load = 1'b0;
      if (i + 1 == zero_d_at) D = '0;
      if (i + 1 == pulse_at) begin
        load = 1'b1;
        D    = 8'hAA;
      end
      tick();
    end
    load = 1'b0;
    check_idle($sformatf("%s end", name));
  endtask

  initial begin
    CLR  = 1'b1;
    load = 1'b1;
    D    = 8'hFF;
    tick();
    check_idle("reset1");
    tick();
    check_idle("reset2");
    CLR  = 1'b0;
    load = 1'b0;

    // LSB-first spec frame: 0,1,1,0,1,0,1,0 on the LSB instance.
    run_frame("f56", 8'b01010110, 0, 0);
    // Back-to-back: load again in the ready cycle; D zeroed at cycle 3.
    run_frame("ff0", 8'b11110000, 3, 0);
`ifdef PISO_PARITY_EN
    run_frame("p07", 8'b00000111, 0, 0);
    run_frame("p56", 8'b01010110, 0, 0);
`endif
    // Ignored load in cycle 4; no second frame may start afterwards.
    run_frame("ign", 8'b10011101, 0, 4);
    tick();
    check_idle("ign after1");
    tick();
    check_idle("ign after2");

    // Abort with CLR in cycle 5.
    D    = 8'b11001010;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int unsigned i = 0; i < 4; i++) tick();
    check("abort c5 busy", {31'b0, busy_l}, 32'd1);
    check("abort c5 sout", {31'b0, sout_l}, {31'b0, exp_bit(8'b11001010, 4, 1'b1)});
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    check_idle("abort");
    for (int unsigned i = 0; i < W + 2; i++) begin
      tick();
      check($sformatf("abort quiet%0d done", i), {31'b0, done_l | done_m}, 32'd0);
      check($sformatf("abort quiet%0d busy", i), {31'b0, busy_l | busy_m}, 32'd0);
    end
    run_frame("post", 8'b00110101, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
